// File: rtl/hpdcache_core_arbiter_credit.sv
// Core-side requester arbiter for the HPDcache: fixed-priority or round-robin grant,
// per-requester outstanding-response credits, stage-2 alignment and response demux.
package hpdcache_core_arbiter_credit_pkg;
    typedef logic [31:0] hpdcache_req_t;
    typedef logic [7:0]  hpdcache_tag_t;

    typedef struct packed {
        logic uncacheable;
        logic io;
    } hpdcache_pma_t;

    typedef struct packed {
        logic [4:0]  sid;
        logic        error;
        logic [31:0] rdata;
    } hpdcache_rsp_t;
endpackage

module hpdcache_core_arbiter_credit #(
    parameter int  NREQ            = 4,
    parameter bit  ARB_RR          = 1'b1,
    parameter int  MAX_OUTSTANDING = 4,
    parameter int  SID_WIDTH       = 5,
    parameter type hpdcache_req_t  = hpdcache_core_arbiter_credit_pkg::hpdcache_req_t,
    parameter type hpdcache_tag_t  = hpdcache_core_arbiter_credit_pkg::hpdcache_tag_t,
    parameter type hpdcache_pma_t  = hpdcache_core_arbiter_credit_pkg::hpdcache_pma_t,
    parameter type hpdcache_rsp_t  = hpdcache_core_arbiter_credit_pkg::hpdcache_rsp_t
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,

    input  logic [NREQ-1:0]      core_req_valid_i,
    output logic [NREQ-1:0]      core_req_ready_o,
    input  hpdcache_req_t        core_req_i          [NREQ],
    input  logic [NREQ-1:0]      core_req_need_rsp_i,
    input  logic [NREQ-1:0]      core_req_abort_i,
    input  hpdcache_tag_t        core_req_tag_i      [NREQ],
    input  hpdcache_pma_t        core_req_pma_i      [NREQ],

    input  logic                 core_rsp_valid_i,
    input  hpdcache_rsp_t        core_rsp_i,
    output logic [NREQ-1:0]      core_rsp_valid_o,
    output hpdcache_rsp_t        core_rsp_o          [NREQ],

    output logic                 arb_req_valid_o,
    input  logic                 arb_req_ready_i,
    output hpdcache_req_t        arb_req_o,
    output logic                 arb_abort_o,
    output hpdcache_tag_t        arb_tag_o,
    output hpdcache_pma_t        arb_pma_o,
    output logic                 arb_s2_valid_o,

    output logic                 idle_o,
    output logic                 err_o
);

    localparam int CW = $clog2(MAX_OUTSTANDING + 1);
    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [CW-1:0]  cnt_q [NREQ];
    logic [CW-1:0]  cnt_d [NREQ];
    logic [IW-1:0]  ptr_q;
    logic [IW-1:0]  lock_q;
    logic           lock_act_q;
    logic [NREQ-1:0] gnt_q;
    logic           s2_q;
    logic           need_q;
    logic           err_q;

    logic [NREQ-1:0] eligible;
    logic [NREQ-1:0] gnt;
    logic [IW-1:0]   win_idx;
    logic            found;
    logic            lock_lost;
    logic            hs;
    logic            need_sel;
    logic [NREQ-1:0] inc;
    logic [NREQ-1:0] dec_abt;
    logic            cnt_err;
    logic            bad_sid;
    logic [SID_WIDTH-1:0] rsp_sid;
    int              idx;
    int              sum;

    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            eligible[i] = core_req_valid_i[i] && (cnt_q[i] < CW'(MAX_OUTSTANDING));
        end
    end

    // A stalled grant stays on lock_q; if that requester drops valid the lock is
    // released and normal arbitration takes over in the same cycle.
    always_comb begin
        gnt       = '0;
        win_idx   = '0;
        found     = 1'b0;
        lock_lost = 1'b0;
        idx       = 0;
        if (lock_act_q) begin
            if (core_req_valid_i[lock_q]) begin
                gnt[lock_q] = 1'b1;
                win_idx     = lock_q;
                found       = 1'b1;
            end else begin
                lock_lost = 1'b1;
            end
        end
        if (!found) begin
            for (int k = 0; k < NREQ; k++) begin
                idx = (ARB_RR ? int'(ptr_q) : 0) + k;
                if (idx >= NREQ) idx = idx - NREQ;
                if (!found && eligible[idx]) begin
                    gnt[idx] = 1'b1;
                    win_idx  = IW'(idx);
                    found    = 1'b1;
                end
            end
        end
    end

    assign arb_req_valid_o  = |gnt;
    assign hs               = arb_req_valid_o && arb_req_ready_i;
    assign core_req_ready_o = arb_req_ready_i ? gnt : '0;

    always_comb begin
        arb_req_o = '0;
        arb_tag_o = '0;
        arb_pma_o = '0;
        need_sel  = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt[i]) begin
                arb_req_o = core_req_i[i];
                need_sel  = core_req_need_rsp_i[i];
            end
            if (gnt_q[i]) begin
                arb_tag_o = core_req_tag_i[i];
                arb_pma_o = core_req_pma_i[i];
            end
        end
    end

    assign arb_abort_o    = |(gnt_q & core_req_abort_i);
    assign arb_s2_valid_o = s2_q;

    assign rsp_sid = core_rsp_i.sid;
    assign bad_sid = core_rsp_valid_i && (int'(rsp_sid) >= NREQ);

    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            core_rsp_valid_o[i] = core_rsp_valid_i && (int'(rsp_sid) == i);
            core_rsp_o[i]       = core_rsp_i;
        end
    end

    // Net counter change is inc - abort - response, clamped to [0, MAX_OUTSTANDING].
    always_comb begin
        cnt_err = 1'b0;
        sum     = 0;
        for (int i = 0; i < NREQ; i++) begin
            inc[i]     = hs && gnt[i] && core_req_need_rsp_i[i];
            dec_abt[i] = s2_q && gnt_q[i] && core_req_abort_i[i] && need_q;
            sum = int'(cnt_q[i]) + (inc[i] ? 1 : 0) - (dec_abt[i] ? 1 : 0)
                - (core_rsp_valid_o[i] ? 1 : 0);
            if (sum < 0) begin
                cnt_d[i] = '0;
                cnt_err  = 1'b1;
            end else if (sum > MAX_OUTSTANDING) begin
                cnt_d[i] = CW'(MAX_OUTSTANDING);
                cnt_err  = 1'b1;
            end else begin
                cnt_d[i] = CW'(sum);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ptr_q      <= '0;
            lock_q     <= '0;
            lock_act_q <= 1'b0;
            gnt_q      <= '0;
            s2_q       <= 1'b0;
            need_q     <= 1'b0;
            err_q      <= 1'b0;
            for (int i = 0; i < NREQ; i++) cnt_q[i] <= '0;
        end else begin
            if (hs) begin
                gnt_q  <= gnt;
                need_q <= need_sel;
                if (ARB_RR) begin
                    ptr_q <= (win_idx == IW'(NREQ - 1)) ? '0 : win_idx + 1'b1;
                end
            end
            s2_q       <= hs;
            lock_act_q <= arb_req_valid_o && !arb_req_ready_i;
            if (arb_req_valid_o && !arb_req_ready_i) lock_q <= win_idx;
            err_q <= err_q | bad_sid | cnt_err | lock_lost;
            for (int i = 0; i < NREQ; i++) cnt_q[i] <= cnt_d[i];
        end
    end

    always_comb begin
        idle_o = !s2_q;
        for (int i = 0; i < NREQ; i++) begin
            if (cnt_q[i] != '0) idle_o = 1'b0;
        end
    end

    assign err_o = err_q;

endmodule

// File: tb/tb_hpdcache_core_arbiter_credit.sv
// Directed bench: dut_a is round-robin with two credits, dut_b is fixed priority
// with four credits; both see the same stimulus and each step checks one of them.
module tb_hpdcache_core_arbiter_credit;
    import hpdcache_core_arbiter_credit_pkg::*;

    localparam int N = 4;

    logic          clk;
    logic          rst_n;
    logic [N-1:0]  valid;
    logic [N-1:0]  need;
    logic [N-1:0]  abort;
    hpdcache_req_t req_in [N];
    hpdcache_tag_t tag_in [N];
    hpdcache_pma_t pma_in [N];
    logic          rsp_valid;
    hpdcache_rsp_t rsp_in;
    logic          arb_ready;

    logic [N-1:0]  a_ready, b_ready;
    logic [N-1:0]  a_rsp_valid, b_rsp_valid;
    hpdcache_rsp_t a_rsp_o [N];
    hpdcache_rsp_t b_rsp_o [N];
    logic          a_arb_valid, b_arb_valid;
    hpdcache_req_t a_arb_req, b_arb_req;
    logic          a_abort, b_abort;
    hpdcache_tag_t a_tag, b_tag;
    hpdcache_pma_t a_pma, b_pma;
    logic          a_s2, b_s2;
    logic          a_idle, b_idle;
    logic          a_err, b_err;

    int checks = 0;
    int errors = 0;

    hpdcache_core_arbiter_credit #(.NREQ(N), .ARB_RR(1'b1), .MAX_OUTSTANDING(2)) dut_a (
        .clk_i(clk), .rst_ni(rst_n),
        .core_req_valid_i(valid), .core_req_ready_o(a_ready), .core_req_i(req_in),
        .core_req_need_rsp_i(need), .core_req_abort_i(abort),
        .core_req_tag_i(tag_in), .core_req_pma_i(pma_in),
        .core_rsp_valid_i(rsp_valid), .core_rsp_i(rsp_in),
        .core_rsp_valid_o(a_rsp_valid), .core_rsp_o(a_rsp_o),
        .arb_req_valid_o(a_arb_valid), .arb_req_ready_i(arb_ready), .arb_req_o(a_arb_req),
        .arb_abort_o(a_abort), .arb_tag_o(a_tag), .arb_pma_o(a_pma),
        .arb_s2_valid_o(a_s2), .idle_o(a_idle), .err_o(a_err)
    );

    hpdcache_core_arbiter_credit #(.NREQ(N), .ARB_RR(1'b0), .MAX_OUTSTANDING(4)) dut_b (
        .clk_i(clk), .rst_ni(rst_n),
        .core_req_valid_i(valid), .core_req_ready_o(b_ready), .core_req_i(req_in),
        .core_req_need_rsp_i(need), .core_req_abort_i(abort),
        .core_req_tag_i(tag_in), .core_req_pma_i(pma_in),
        .core_rsp_valid_i(rsp_valid), .core_rsp_i(rsp_in),
        .core_rsp_valid_o(b_rsp_valid), .core_rsp_o(b_rsp_o),
        .arb_req_valid_o(b_arb_valid), .arb_req_ready_i(arb_ready), .arb_req_o(b_arb_req),
        .arb_abort_o(b_abort), .arb_tag_o(b_tag), .arb_pma_o(b_pma),
        .arb_s2_valid_o(b_s2), .idle_o(b_idle), .err_o(b_err)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        tick();
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    logic [N-1:0] rr_exp [5];
    int           rr_idx [5];

    initial begin
        rr_exp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        rr_idx = '{0, 1, 2, 3, 0};
        rst_n     = 1'b0;
        valid     = '0;
        need      = '0;
        abort     = '0;
        rsp_valid = 1'b0;
        rsp_in    = '0;
        arb_ready = 1'b1;
        for (int i = 0; i < N; i++) begin
            req_in[i] = hpdcache_req_t'($urandom_range(32'h7fff_ffff, 1));
            tag_in[i] = hpdcache_tag_t'($urandom_range(255, 0));
            pma_in[i] = hpdcache_pma_t'(i);
        end

        // reset state
        #12;
        chk("rst_idle", 64'(a_idle), 64'(1));
        chk("rst_err", 64'(a_err), 64'(0));
        chk("rst_arb_valid", 64'(a_arb_valid), 64'(0));
        chk("rst_s2", 64'(a_s2), 64'(0));
        chk("rst_ready", 64'(a_ready), 64'(0));
        rst_n = 1'b1;
        tick();

        // round-robin vs fixed priority, all valid, no responses needed
        valid = 4'b1111;
        #1;
        for (int c = 0; c < 5; c++) begin
            chk("rr_gnt", 64'(a_ready), 64'(rr_exp[c]));
            chk("rr_req", 64'(a_arb_req), 64'(req_in[rr_idx[c]]));
            chk("fp_gnt", 64'(b_ready), 64'(4'b0001));
            tick();
        end
        valid = '0;
        do_reset();

        // credit limit on dut_a (two outstanding)
        valid = 4'b0010;
        need  = 4'b0010;
        #1;
        chk("cr_rdy0", 64'(a_ready), 64'(4'b0010));
        tick();
        chk("cr_rdy1", 64'(a_ready), 64'(4'b0010));
        tick();
        chk("cr_block", 64'(a_ready), 64'(0));
        chk("cr_arbv", 64'(a_arb_valid), 64'(0));
        tick();
        chk("cr_hold", 64'(a_ready), 64'(0));
        rsp_in.sid   = 5'd1;
        rsp_in.rdata = $urandom;
        rsp_valid    = 1'b1;
        #1;
        chk("rsp_demux", 64'(a_rsp_valid), 64'(4'b0010));
        chk("rsp_bcast", 64'(a_rsp_o[3]), 64'(rsp_in));
        chk("cr_same", 64'(a_ready), 64'(0));
        tick();
        rsp_valid = 1'b0;
        #1;
        chk("cr_reen", 64'(a_ready), 64'(4'b0010));
        valid = '0;
        need  = '0;
        do_reset();

        // grant lock on dut_b (fixed priority)
        arb_ready = 1'b0;
        valid     = 4'b0100;
        #1;
        chk("lk_rdy", 64'(b_ready), 64'(0));
        chk("lk_valid", 64'(b_arb_valid), 64'(1));
        chk("lk_req", 64'(b_arb_req), 64'(req_in[2]));
        tick();
        valid = 4'b0101;
        #1;
        chk("lk_hold", 64'(b_arb_req), 64'(req_in[2]));
        tick();
        chk("lk_hold2", 64'(b_arb_req), 64'(req_in[2]));
        arb_ready = 1'b1;
        #1;
        chk("lk_rel", 64'(b_ready), 64'(4'b0100));
        tick();
        chk("lk_next", 64'(b_ready), 64'(4'b0001));
        chk("lk_err", 64'(b_err), 64'(0));
        valid = '0;
        do_reset();

        // abort returns the credit of requester 3
        valid = 4'b1000;
        need  = 4'b1000;
        #1;
        chk("ab_rdy", 64'(a_ready), 64'(4'b1000));
        tick();
        valid = '0;
        need  = '0;
        abort = 4'b1000;
        #1;
        chk("ab_s2", 64'(a_s2), 64'(1));
        chk("ab_abort", 64'(a_abort), 64'(1));
        chk("ab_tag", 64'(a_tag), 64'(tag_in[3]));
        chk("ab_busy", 64'(a_idle), 64'(0));
        tick();
        abort = '0;
        #1;
        chk("ab_idle", 64'(a_idle), 64'(1));
        chk("ab_s2off", 64'(a_s2), 64'(0));
        chk("ab_err", 64'(a_err), 64'(0));

        // simultaneous increment and response on requester 0
        valid = 4'b0001;
        need  = 4'b0001;
        tick();
        rsp_in.sid = 5'd0;
        rsp_valid  = 1'b1;
        #1;
        chk("sm_rdy", 64'(a_ready), 64'(4'b0001));
        tick();
        rsp_valid = 1'b0;
        #1;
        chk("sm_rdy2", 64'(a_ready), 64'(4'b0001));
        tick();
        chk("sm_full", 64'(a_ready), 64'(0));
        chk("sm_err", 64'(a_err), 64'(0));
        valid     = '0;
        need      = '0;
        rsp_valid = 1'b1;
        tick();
        tick();
        rsp_valid = 1'b0;
        #1;
        chk("sm_idle", 64'(a_idle), 64'(1));
        chk("sm_err2", 64'(a_err), 64'(0));

        // out-of-range SID
        rsp_in.sid = 5'd7;
        rsp_valid  = 1'b1;
        #1;
        chk("er_demux", 64'(a_rsp_valid), 64'(0));
        chk("er_pre", 64'(a_err), 64'(0));
        tick();
        rsp_valid = 1'b0;
        #1;
        chk("er_set", 64'(a_err), 64'(1));
        tick();
        tick();
        chk("er_sticky", 64'(a_err), 64'(1));
        do_reset();
        chk("er_clr", 64'(a_err), 64'(0));

        // response to a zero counter
        rsp_in.sid = 5'd2;
        rsp_valid  = 1'b1;
        tick();
        rsp_valid = 1'b0;
        #1;
        chk("er_zero", 64'(a_err), 64'(1));
        do_reset();

        // lock loss on dut_b
        arb_ready = 1'b0;
        valid     = 4'b0010;
        tick();
        valid = '0;
        tick();
        chk("er_lock", 64'(b_err), 64'(1));
        arb_ready = 1'b1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
